// File: rtl/marb_pkg.sv
// rtl/marb_pkg.sv - shared types for the memory arbiter client scheduler
package marb_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'b00,
        RR     = 2'b01,
        DPRIO  = 2'b10
    } arb_mode_t;

    // Bit 0 enable, bits [2:1] arbitration mode; the upper bits are reserved.
    typedef struct packed {
        logic [28:0] rsvd;
        arb_mode_t   mode;
        logic        en;
    } ctrl_reg_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    typedef logic [7:0] dprio_reg_t;

endpackage

// File: rtl/marb_winner_sel.sv
// rtl/marb_winner_sel.sv - combinational pick of the next client to grant
module marb_winner_sel
    import marb_pkg::*;
#(
    parameter int N_P     = 3,
    parameter int IDX_W_P = 2
) (
    input  logic [N_P-1:0]     req_i,
    input  arb_mode_t          mode_i,
    input  logic [IDX_W_P-1:0] rr_ptr_i,
    input  logic [N_P*8-1:0]   dprio_i,
    output logic [IDX_W_P-1:0] win_idx_o,
    output logic               win_vld_o
);

    always_comb begin
        int         idx;
        logic       found;
        dprio_reg_t best;
        idx       = 0;
        found     = 1'b0;
        best      = '0;
        win_idx_o = '0;
        case (mode_i)
            RR: begin
                for (int k = 0; k < N_P; k++) begin
                    idx = (int'(rr_ptr_i) + k) % N_P;
                    if (!found && req_i[idx]) begin
                        found     = 1'b1;
                        win_idx_o = IDX_W_P'(idx);
                    end
                end
            end
            DPRIO: begin
                // Strict greater-than keeps the lowest index on ties.
                for (int i = 0; i < N_P; i++) begin
                    if (req_i[i] && (!found || dprio_i[8*i +: 8] > best)) begin
                        found     = 1'b1;
                        best      = dprio_i[8*i +: 8];
                        win_idx_o = IDX_W_P'(i);
                    end
                end
            end
            default: begin
                for (int i = N_P - 1; i >= 0; i--) begin
                    if (req_i[i]) win_idx_o = IDX_W_P'(i);
                end
            end
        endcase
    end

    assign win_vld_o = |req_i;

endmodule

// File: rtl/marb_client_sched.sv
// rtl/marb_client_sched.sv - memory port scheduler for N clients; MARB_AGING_EN adds starvation override
module marb_client_sched
    import marb_pkg::*;
#(
    parameter int MEM_ARB_CLIENTS_P = 3,
    parameter int ADDR_W_P          = 32,
    parameter int DATA_W_P          = 32,
    parameter int AGE_MAX_P         = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [31:0]                           ctrl,
    input  logic [MEM_ARB_CLIENTS_P*8-1:0]        dprio,
    input  logic [MEM_ARB_CLIENTS_P-1:0]          dprio_wstrb,
    input  logic [MEM_ARB_CLIENTS_P-1:0]          c_valid,
    output logic [MEM_ARB_CLIENTS_P-1:0]          c_ready,
    input  logic [MEM_ARB_CLIENTS_P*ADDR_W_P-1:0] c_addr,
    input  logic [MEM_ARB_CLIENTS_P*DATA_W_P-1:0] c_wdata,
    input  logic [MEM_ARB_CLIENTS_P-1:0]          c_we,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [ADDR_W_P-1:0]                   m_addr,
    output logic [DATA_W_P-1:0]                   m_wdata,
    output logic                                  m_we,
    output logic [$clog2(MEM_ARB_CLIENTS_P)-1:0]  m_client,
    output logic                                  busy
);

    localparam int N     = MEM_ARB_CLIENTS_P;
    localparam int IDX_W = $clog2(MEM_ARB_CLIENTS_P);

    ctrl_reg_t        ctrl_s;
    sched_state_t     state_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [N*8-1:0]   dprio_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             win_vld;
    logic             take;

    assign ctrl_s = ctrl_reg_t'(ctrl);

    marb_winner_sel #(
        .N_P     (N),
        .IDX_W_P (IDX_W)
    ) u_winner_sel (
        .req_i     (c_valid),
        .mode_i    (ctrl_s.mode),
        .rr_ptr_i  (rr_ptr_q),
        .dprio_i   (dprio_q),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

`ifdef MARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX_P + 1);

    logic [AGE_W-1:0] age_q [N];
    logic [N-1:0]     aged;
    logic [IDX_W-1:0] aged_idx;
    logic             unused_ctrl;

    assign unused_ctrl = ^ctrl_s.rsvd;

    always_comb begin
        aged_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            aged[i] = c_valid[i] && (age_q[i] == AGE_W'(AGE_MAX_P));
            if (aged[i]) aged_idx = IDX_W'(i);
        end
    end

    // A starved client overrides whatever the mode would have picked.
    assign sel_idx = (|aged) ? aged_idx : win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!c_valid[i] ||
                    (state_q == GRANT && int'(gnt_idx_q) == i) ||
                    (take && int'(sel_idx) == i)) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_W'(AGE_MAX_P)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_ctrl;

    assign unused_ctrl = ^{ctrl_s.rsvd, AGE_MAX_P[0]};
    assign sel_idx     = win_idx;
`endif

    assign take = (state_q == IDLE) && ctrl_s.en && win_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q   <= GRANT;
                        gnt_idx_q <= sel_idx;
                    end
                end
                GRANT: begin
                    if (m_ready) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= (int'(gnt_idx_q) == N - 1) ? '0 : gnt_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dprio_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (dprio_wstrb[i]) dprio_q[8*i +: 8] <= dprio[8*i +: 8];
            end
        end
    end

    assign busy     = (state_q == GRANT);
    assign m_valid  = busy;
    assign m_client = gnt_idx_q;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_we    = 1'b0;
        c_ready = '0;
        if (busy) begin
            m_addr             = c_addr[int'(gnt_idx_q)*ADDR_W_P +: ADDR_W_P];
            m_wdata            = c_wdata[int'(gnt_idx_q)*DATA_W_P +: DATA_W_P];
            m_we               = c_we[gnt_idx_q];
            c_ready[gnt_idx_q] = m_ready;
        end
    end

endmodule

// File: tb/tb_marb_client_sched.sv
// tb/tb_marb_client_sched.sv - randomized and directed checks of marb_client_sched against a behavioural model
module tb_marb_client_sched;

    localparam int N = 3;
`ifdef MARB_AGING_EN
    localparam int AGE_MAX = 4;
`else
    localparam int AGE_MAX = 15;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ctrl;
    logic [N*8-1:0] dprio;
    logic [N-1:0]  dprio_wstrb;
    logic [N-1:0]  c_valid;
    logic [N-1:0]  c_ready;
    logic [N*32-1:0] c_addr;
    logic [N*32-1:0] c_wdata;
    logic [N-1:0]  c_we;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic          m_we;
    logic [1:0]    m_client;
    logic          busy;

    marb_client_sched #(
        .MEM_ARB_CLIENTS_P (N),
        .ADDR_W_P          (32),
        .DATA_W_P          (32),
        .AGE_MAX_P         (AGE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .dprio       (dprio),
        .dprio_wstrb (dprio_wstrb),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_we        (c_we),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_we        (m_we),
        .m_client    (m_client),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: is a transfer in flight, for whom, next RR start, shadow priorities, ages.
    bit mb;
    int mg;
    int mrr;
    int sh  [N];
    int age [N];
    int done_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mb = 1'b0;
        mg = 0;
        mrr = 0;
        done_idx = -1;
        for (int i = 0; i < N; i++) begin
            sh[i]  = 0;
            age[i] = 0;
        end
    endtask

    function automatic int model_pick();
        int mx;
`ifdef MARB_AGING_EN
        for (int i = 0; i < N; i++)
            if (c_valid[i] && age[i] >= AGE_MAX) return i;
`endif
        if (ctrl[2:1] == 2'b01) begin
            for (int k = 0; k < N; k++)
                if (c_valid[(mrr + k) % N]) return (mrr + k) % N;
        end else if (ctrl[2:1] == 2'b10) begin
            mx = -1;
            for (int i = 0; i < N; i++)
                if (c_valid[i] && sh[i] > mx) mx = sh[i];
            for (int i = 0; i < N; i++)
                if (c_valid[i] && sh[i] == mx) return i;
        end
        for (int i = 0; i < N; i++)
            if (c_valid[i]) return i;
        return 0;
    endfunction

    task automatic model_check();
        logic [N-1:0] exp_rdy;
        exp_rdy = (mb && m_ready) ? N'(1 << mg) : '0;
        check("m_valid", m_valid, mb);
        check("busy", busy, mb);
        check("c_ready", c_ready, exp_rdy);
        if (mb) begin
            check("m_client", m_client, mg);
            check("m_addr", m_addr, c_addr[mg*32 +: 32]);
            check("m_wdata", m_wdata, c_wdata[mg*32 +: 32]);
            check("m_we", m_we, c_we[mg]);
        end else begin
            check("m_addr_idle", m_addr, 0);
        end
    endtask

    task automatic model_update();
        int p;
        bit ng;
        bit ob;
        int og;
        ob = mb;
        og = mg;
        ng = 1'b0;
        done_idx = -1;
        p = model_pick();
        if (!mb) begin
            if (ctrl[0] && c_valid != 0) begin
                mb = 1'b1;
                mg = p;
                ng = 1'b1;
            end
        end else if (m_ready) begin
            mb = 1'b0;
            done_idx = mg;
            mrr = (mg + 1) % N;
        end
`ifdef MARB_AGING_EN
        for (int i = 0; i < N; i++) begin
            if (!c_valid[i] || (ob && og == i) || (ng && p == i)) age[i] = 0;
            else if (age[i] < AGE_MAX) age[i]++;
        end
`else
        if (ob && og < 0) $display("model state inconsistent");
`endif
        for (int i = 0; i < N; i++)
            if (dprio_wstrb[i]) sh[i] = dprio[8*i +: 8];
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        logic [31:0] held;
        bit got2;
        int gk;

        rst = 1'b1;
        ctrl = 32'h1;
        dprio = '0;
        dprio_wstrb = '0;
        c_valid = 3'b111;
        c_addr = '0;
        c_wdata = '0;
        c_we = '0;
        m_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_c_ready", c_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_client", m_client, 0);
        check("rst_m_addr", m_addr, 0);
        rst = 1'b0;

        // Round robin from a fresh reset: 0,1,2,0 on every other cycle.
        ctrl = 32'h3;
        c_valid = 3'b111;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (m_valid) q.push_back(int'(m_client));
        end
        check("rr_grants", q.size(), 4);
        for (int i = 0; i < q.size() && i < 4; i++) check("rr_order", q[i], (i == 3) ? 0 : i);
        c_valid = '0;
        step();
        m_ready = 1'b0;

        // Static: lowest requester wins.
        ctrl = 32'h1;
        c_valid = 3'b110;
        c_addr[63:32] = 32'h1000_0010;
        step();
        check("t1_valid", m_valid, 1);
        check("t1_client", m_client, 1);
        m_ready = 1'b1;
        #1;
        check("t1_c_ready", c_ready, 3'b010);
        step();
        c_valid = '0;
        m_ready = 1'b0;
        step();

        // Dynamic priority, then a shadow update while a transfer is in flight.
        ctrl = 32'h0;
        c_valid = 3'b111;
        dprio = {8'h10, 8'h40, 8'h40};
        dprio_wstrb = 3'b111;
        step();
        dprio_wstrb = '0;
        ctrl = 32'h5;
        step();
        check("t3_client0", m_client, 0);
        m_ready = 1'b1;
        dprio[23:16] = 8'h50;
        dprio_wstrb = 3'b100;
        step();
        dprio_wstrb = '0;
        m_ready = 1'b0;
        step();
        check("t3_client2", m_client, 2);
        check("t3_valid", m_valid, 1);
        m_ready = 1'b1;
        step();
        c_valid = '0;
        m_ready = 1'b0;

        // Stall with enable dropped mid-transfer.
        ctrl = 32'h1;
        c_valid = 3'b001;
        c_addr[31:0] = 32'hA5A5_0004;
        step();
        held = m_addr;
        check("t4_addr0", held, 32'hA5A5_0004);
        ctrl = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_hold_valid", m_valid, 1);
            check("t4_hold_addr", m_addr, held);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        c_valid = 3'b010;
        step();
        step();
        check("t4_no_regrant", m_valid, 0);
        c_valid = '0;

        // Reset during a grant, rr_ptr must restart at 0.
        ctrl = 32'h3;
        c_valid = 3'b111;
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        step();
        check("t5_pre_valid", m_valid, 1);
        m_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("t5_m_valid", m_valid, 0);
        check("t5_c_ready", c_ready, 0);
        check("t5_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b0;
        step();
        check("t5_rr0", m_client, 0);
        m_ready = 1'b1;
        step();
        c_valid = '0;
        m_ready = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!c_valid[i] && $urandom_range(2) == 0) begin
                    c_valid[i] = 1'b1;
                    c_addr[i*32 +: 32] = $urandom;
                    c_wdata[i*32 +: 32] = $urandom;
                    c_we[i] = 1'($urandom_range(1));
                end
            end
            m_ready = 1'($urandom_range(1));
            if ($urandom_range(15) == 0)
                ctrl = {29'b0, 2'($urandom_range(3)), 1'($urandom_range(7) != 0)};
            dprio_wstrb = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            dprio = 24'($urandom);
            step();
            if (done_idx >= 0) c_valid[done_idx] = 1'b0;
        end
        dprio_wstrb = '0;

`ifdef MARB_AGING_EN
        // Client 0 hogs static mode; client 2 must win once its age saturates.
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ctrl = 32'h1;
        c_valid = 3'b101;
        m_ready = 1'b1;
        got2 = 1'b0;
        gk = -1;
        for (int k = 0; k < 12 && !got2; k++) begin
            step();
            if (m_valid && m_client == 2'd2) begin
                got2 = 1'b1;
                gk = k;
            end
        end
        check("t6_aged_grant", got2, 1);
        check("t6_aged_cycle", gk, 4);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
